// File: rtl/nxn_window_filter.sv
// nxn_window_filter: streaming KSIZE x KSIZE neighbourhood filter.
// A raster stream feeds KSIZE-1 line buffers and a KSIZE x KSIZE window.
// A three-stage pipeline then produces passthrough, binomial (gaussian) or
// box-mean results. The stream is treated as continuous, with no edge padding.
module nxn_window_filter #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WIDTH = 640,
    parameter int KSIZE      = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  validin,
    input  logic                  blanking_in,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  validout,
    output logic                  blanking_out
);
    localparam int H  = (KSIZE - 1) / 2;
    localparam int F  = H * LINE_WIDTH + H;          // samples needed before the centre is real
    localparam int CW = $clog2(F + 1);
    localparam int PW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int GS = (KSIZE == 3) ? 4 : 8;        // binomial normalisation shift
    localparam int BR = (KSIZE == 3) ? 7282 : 2621;  // 65536 / KSIZE^2, rounded
    localparam int RW = DATA_WIDTH + 4;              // weighted row: pixel x (coef sum <= 16)
    localparam int GW = DATA_WIDTH + 9;              // weighted 2-D sum <= 256 x pixel, plus rounding
    localparam int BW = DATA_WIDTH + 3;              // plain row: up to 5 pixels
    localparam int BT = DATA_WIDTH + 5;              // plain 2-D sum: up to 25 pixels
    localparam int MW = DATA_WIDTH + 20;             // scaled box sum plus rounding term
    localparam logic [CW-1:0]         F_C      = CW'(F);
    localparam logic [PW-1:0]         PTR_LAST = PW'(LINE_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] PIX_MAX  = '1;

    generate
        if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
            $error("nxn_window_filter: KSIZE must be 3 or 5");
        end
    endgenerate

    // Per-axis binomial coefficient for tap idx.
    function automatic logic [2:0] coef(input int idx);
        logic [2:0] c;
        if (KSIZE == 3) begin
            c = (idx == 1) ? 3'd2 : 3'd1;
        end else begin
            case (idx)
                1, 3:    c = 3'd4;
                2:       c = 3'd6;
                default: c = 3'd1;
            endcase
        end
        return c;
    endfunction

    // storage
    logic [DATA_WIDTH-1:0] lb_q  [KSIZE-1][LINE_WIDTH];
    logic [DATA_WIDTH-1:0] win_q [KSIZE][KSIZE];
    logic [DATA_WIDTH-1:0] win_d [KSIZE][KSIZE];
    logic [DATA_WIDTH-1:0] col_s [KSIZE];
    logic                  accept_s;

    // control
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ptr_q, ptr_d;

    // stage 1 sidebands (window itself is the stage-1 data)
    logic [1:0] mode1_q, mode1_d;
    logic       v1_q, v1_d;
    logic       b1_q, b1_d;

    // stage 2
    logic [RW-1:0]         grow_q [KSIZE];
    logic [RW-1:0]         grow_d [KSIZE];
    logic [BW-1:0]         brow_q [KSIZE];
    logic [BW-1:0]         brow_d [KSIZE];
    logic [DATA_WIDTH-1:0] cen_q, cen_d;
    logic [1:0]            mode2_q, mode2_d;
    logic                  v2_q, v2_d;
    logic                  b2_q, b2_d;

    // stage 3
    logic [GW-1:0]         gsum_s, grnd_s;
    logic [BT-1:0]         bsum_s;
    logic [MW-1:0]         bprod_s;
    logic [DATA_WIDTH-1:0] gres_s, bres_s, res_s;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  validout_q, validout_d;
    logic                  blank_q, blank_d;

    assign accept_s = validin & ~reset;

    // New window column: current pixel on top, then one pixel per buffered line above it.
    always_comb begin
        col_s[0] = din;
        for (int i = 1; i < KSIZE; i++) begin
            col_s[i] = lb_q[i-1][ptr_q];
        end
    end

    // Stage 1: counter, line pointer, window shift and sideband capture.
    always_comb begin
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        win_d = win_q;
        if (accept_s) begin
            if (cnt_q != F_C) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
            for (int r = 0; r < KSIZE; r++) begin
                win_d[r][0] = col_s[r];
                for (int c = 1; c < KSIZE; c++) begin
                    win_d[r][c] = win_q[r][c-1];
                end
            end
        end else begin
            win_d = win_q;
        end
        v1_d    = accept_s & (cnt_q == F_C);
        mode1_d = mode;
        b1_d    = blanking_in;
    end

    // Stage 2: horizontal weighted and plain row sums, plus the centre pixel.
    always_comb begin
        for (int r = 0; r < KSIZE; r++) begin
            grow_d[r] = '0;
            brow_d[r] = '0;
            for (int c = 0; c < KSIZE; c++) begin
                grow_d[r] = grow_d[r] + RW'(win_q[r][c]) * RW'(coef(c));
                brow_d[r] = brow_d[r] + BW'(win_q[r][c]);
            end
        end
        cen_d   = win_q[H][H];
        mode2_d = mode1_q;
        v2_d    = v1_q;
        b2_d    = b1_q;
    end

    // Stage 3: vertical combine, normalise, saturate and select by mode.
    always_comb begin
        gsum_s = '0;
        bsum_s = '0;
        for (int r = 0; r < KSIZE; r++) begin
            gsum_s = gsum_s + GW'(grow_q[r]) * GW'(coef(r));
            bsum_s = bsum_s + BT'(brow_q[r]);
        end
        grnd_s  = (gsum_s + GW'(1 << (GS - 1))) >> GS;
        bprod_s = (MW'(bsum_s) * MW'(BR) + MW'(32768)) >> 16;
        gres_s  = (grnd_s > GW'(PIX_MAX)) ? PIX_MAX : grnd_s[DATA_WIDTH-1:0];
        bres_s  = (bprod_s > MW'(PIX_MAX)) ? PIX_MAX : bprod_s[DATA_WIDTH-1:0];
        case (mode2_q)
            2'b01:   res_s = gres_s;
            2'b10:   res_s = bres_s;
            default: res_s = cen_q;
        endcase
        if (v2_q) begin
            dout_d = res_s;
        end else begin
            dout_d = dout_q;
        end
        validout_d = v2_q;
        blank_d    = b2_q;
    end

    // Control and pipeline registers; reset clears every stage and the counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            ptr_q      <= '0;
            mode1_q    <= 2'b00;
            v1_q       <= 1'b0;
            b1_q       <= 1'b0;
            for (int r = 0; r < KSIZE; r++) begin
                grow_q[r] <= '0;
                brow_q[r] <= '0;
            end
            cen_q      <= '0;
            mode2_q    <= 2'b00;
            v2_q       <= 1'b0;
            b2_q       <= 1'b0;
            dout_q     <= '0;
            validout_q <= 1'b0;
            blank_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            mode1_q    <= mode1_d;
            v1_q       <= v1_d;
            b1_q       <= b1_d;
            grow_q     <= grow_d;
            brow_q     <= brow_d;
            cen_q      <= cen_d;
            mode2_q    <= mode2_d;
            v2_q       <= v2_d;
            b2_q       <= b2_d;
            dout_q     <= dout_d;
            validout_q <= validout_d;
            blank_q    <= blank_d;
        end
    end

    // Window register: changes only on accepted samples; stale content is masked by the counter.
    always_ff @(posedge clock) begin
        win_q <= win_d;
    end

    // Line buffers: each delays its input column entry by exactly one line.
    always_ff @(posedge clock) begin
        if (accept_s) begin
            for (int i = 0; i < KSIZE - 1; i++) begin
                lb_q[i][ptr_q] <= col_s[i];
            end
        end
    end

    assign dout         = dout_q;
    assign validout     = validout_q;
    assign blanking_out = blank_q;

endmodule

// File: tb/tb_nxn_window_filter.sv
// Testbench for nxn_window_filter: a 3x3 and a 5x5 instance share one stimulus stream.
// The bench keeps a sample history and a 3-deep expectation pipe per instance.
module tb_nxn_window_filter;
    localparam int DW   = 8;
    localparam int LW3  = 8;
    localparam int LW5  = 16;
    localparam int F3   = LW3 + 1;
    localparam int F5   = 2 * LW5 + 2;
    localparam int HMAX = 4096;

    typedef struct {
        logic [1:0] mode;
        int         kind;   // 0 constant, 1 ramp, 2 random, 3 random with mode hopping
        int         val;
        int         gap;    // 0 continuous, 1 toggling, 2 random validin
        int         nsamp;
        int         exp3;   // hand-computed dout for constant streams, -1 = use model
        int         exp5;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset, validin, blanking_in;
    logic [DW-1:0] din;
    logic [1:0]    mode;
    logic [DW-1:0] dout3, dout5;
    logic          vo3, vo5, bo3, bo5;

    always #5 clock = ~clock;

    nxn_window_filter #(.DATA_WIDTH(DW), .LINE_WIDTH(LW3), .KSIZE(3)) dut3 (
        .clock(clock), .reset(reset), .din(din), .validin(validin),
        .blanking_in(blanking_in), .mode(mode),
        .dout(dout3), .validout(vo3), .blanking_out(bo3));

    nxn_window_filter #(.DATA_WIDTH(DW), .LINE_WIDTH(LW5), .KSIZE(5)) dut5 (
        .clock(clock), .reset(reset), .din(din), .validin(validin),
        .blanking_in(blanking_in), .mode(mode),
        .dout(dout5), .validout(vo5), .blanking_out(bo5));

    int total = 0;
    int bad   = 0;
    int hist [HMAX];
    int cn = 0;
    int pv [2][3];
    int pb [2][3];
    int pd [2][3];
    int pk [2][3];
    int hold_d [2];
    int hold_k [2];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Direct (non-separable) reference for the window centred on sample n - F.
    function automatic int model(input int k, input int lw, input int md, input int n);
        int w [5];
        int h, sum, s, res;
        h = (k - 1) / 2;
        if (k == 3) begin
            w[0] = 1; w[1] = 2; w[2] = 1; w[3] = 0; w[4] = 0;
        end else begin
            w[0] = 1; w[1] = 4; w[2] = 6; w[3] = 4; w[4] = 1;
        end
        sum = 0;
        if (md == 1) begin
            for (int r = 0; r < k; r++)
                for (int c = 0; c < k; c++)
                    sum += w[r] * w[c] * hist[n - r * lw - c];
            s = (k == 3) ? 4 : 8;
            res = (sum + (1 << (s - 1))) >> s;
        end else if (md == 2) begin
            for (int r = 0; r < k; r++)
                for (int c = 0; c < k; c++)
                    sum += hist[n - r * lw - c];
            res = (sum * ((k == 3) ? 7282 : 2621) + 32768) >> 16;
        end else begin
            res = hist[n - h * lw - h];
        end
        if (res > 255) res = 255;
        return res;
    endfunction

    // One clock: drive inputs, advance the expectation pipe, compare outputs #1 after the edge.
    task automatic step(input logic v, input logic b, input logic [DW-1:0] d,
                        input logic [1:0] m, input logic rst, input int e3, input int e5);
        int nv [2];
        int nd [2];
        int nk [2];
        int kk, lw, ff, ee;
        logic [DW-1:0] od;
        logic ov, ob;
        reset = rst; validin = v; blanking_in = b; din = d; mode = m;
        if (v && !rst && cn < HMAX) hist[cn] = int'(d);
        for (int i = 0; i < 2; i++) begin
            kk = (i == 0) ? 3 : 5;
            lw = (i == 0) ? LW3 : LW5;
            ff = (i == 0) ? F3 : F5;
            ee = (i == 0) ? e3 : e5;
            nv[i] = (v && !rst && cn >= ff && cn < HMAX) ? 1 : 0;
            nk[i] = 0;
            nd[i] = 0;
            if (nv[i] == 1) begin
                if (m == 2'b00 || m == 2'b11 || cn >= 2 * ff) begin
                    nk[i] = 1;
                    nd[i] = (ee >= 0) ? ee : model(kk, lw, int'(m), cn);
                end
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int s = 0; s < 3; s++) begin
                    pv[i][s] = 0; pb[i][s] = 0; pd[i][s] = 0; pk[i][s] = 0;
                end
                hold_d[i] = 0;
                hold_k[i] = 1;
            end else begin
                for (int s = 2; s > 0; s--) begin
                    pv[i][s] = pv[i][s-1]; pb[i][s] = pb[i][s-1];
                    pd[i][s] = pd[i][s-1]; pk[i][s] = pk[i][s-1];
                end
                pv[i][0] = nv[i]; pb[i][0] = b ? 1 : 0;
                pd[i][0] = nd[i]; pk[i][0] = nk[i];
            end
        end
        if (rst) cn = 0;
        else if (v) cn++;
        for (int i = 0; i < 2; i++) begin
            kk = (i == 0) ? 3 : 5;
            od = (i == 0) ? dout3 : dout5;
            ov = (i == 0) ? vo3 : vo5;
            ob = (i == 0) ? bo3 : bo5;
            chk($sformatf("k%0d_validout", kk), int'(ov), pv[i][2]);
            chk($sformatf("k%0d_blanking_out", kk), int'(ob), pb[i][2]);
            if (pv[i][2] == 1) begin
                if (pk[i][2] == 1) begin
                    chk($sformatf("k%0d_dout", kk), int'(od), pd[i][2]);
                    hold_d[i] = pd[i][2];
                    hold_k[i] = 1;
                end else begin
                    hold_k[i] = 0;
                end
            end else if (hold_k[i] == 1) begin
                chk($sformatf("k%0d_dout_hold", kk), int'(od), hold_d[i]);
            end
        end
    endtask

    // Reset (with a sample present that must be dropped), then stream one table record.
    task automatic run_vec(input vec_t tv);
        int acc = 0;
        int cyc = 0;
        logic v;
        logic [DW-1:0] d;
        logic [1:0] m;
        step(1'b1, 1'b1, 8'd99, tv.mode, 1'b1, -1, -1);
        while (acc < tv.nsamp && cyc < 4 * tv.nsamp) begin
            case (tv.gap)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom % 2);
            endcase
            case (tv.kind)
                0:       d = DW'(tv.val);
                1:       d = DW'(acc + tv.val);
                default: d = DW'($urandom);
            endcase
            m = (tv.kind == 3) ? 2'((cyc / 5) % 4) : tv.mode;
            if (tv.kind == 0) step(v, 1'($urandom % 2), d, m, 1'b0, tv.exp3, tv.exp5);
            else              step(v, 1'($urandom % 2), d, m, 1'b0, -1, -1);
            if (v) acc++;
            cyc++;
        end
    endtask

    initial begin
        vec_t tbl [11];
        int first3, first5;
        int obs3 [6];
        int obs5 [6];
        int pat [6];

        tbl[0]  = '{2'b00, 1, 0,   0, 40,  -1,  -1};   // ramp passthrough, continuous
        tbl[1]  = '{2'b00, 1, 0,   1, 40,  -1,  -1};   // ramp passthrough, validin toggling
        tbl[2]  = '{2'b01, 0, 100, 0, 90,  100, 100};
        tbl[3]  = '{2'b10, 0, 100, 0, 90,  100, 100};
        tbl[4]  = '{2'b01, 0, 255, 0, 90,  255, 255};  // gaussian saturation
        tbl[5]  = '{2'b10, 0, 255, 2, 90,  255, 255};  // box saturation, random gaps
        tbl[6]  = '{2'b10, 0, 200, 0, 90,  200, 200};
        tbl[7]  = '{2'b11, 0, 77,  1, 50,  77,  77};   // reserved mode behaves as passthrough
        tbl[8]  = '{2'b01, 2, 0,   2, 120, -1,  -1};
        tbl[9]  = '{2'b10, 2, 0,   0, 120, -1,  -1};
        tbl[10] = '{2'b00, 3, 0,   0, 140, -1,  -1};   // mode changes mid-stream

        step(1'b0, 1'b0, 8'd0, 2'b00, 1'b1, -1, -1);
        step(1'b0, 1'b0, 8'd0, 2'b00, 1'b1, -1, -1);
        for (int t = 0; t < 11; t++) run_vec(tbl[t]);

        // Mid-stream reset: outputs clear next cycle, priming restarts from zero.
        for (int j = 0; j < 60; j++) step(1'b1, 1'b1, DW'(j), 2'b00, 1'b0, -1, -1);
        step(1'b1, 1'b1, 8'd5, 2'b00, 1'b1, -1, -1);
        chk("rst_k3_validout", int'(vo3), 0);
        chk("rst_k3_dout", int'(dout3), 0);
        chk("rst_k3_blanking", int'(bo3), 0);
        chk("rst_k5_validout", int'(vo5), 0);
        first3 = -1;
        first5 = -1;
        for (int j = 1; j <= 60; j++) begin
            step(1'b1, 1'b0, DW'(50 + j), 2'b00, 1'b0, -1, -1);
            if (first3 < 0 && vo3 === 1'b1) begin
                first3 = j;
                chk("reprime_k3_dout", int'(dout3), 51);
            end
            if (first5 < 0 && vo5 === 1'b1) begin
                first5 = j;
                chk("reprime_k5_dout", int'(dout5), 51);
            end
        end
        chk("reprime_k3_first", first3, 12);
        chk("reprime_k5_first", first5, 37);

        // Two-cycle blanking pulse must reappear exactly three cycles later.
        pat[0] = 0; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0; pat[5] = 0;
        for (int vv = 0; vv < 2; vv++) begin
            for (int j = 0; j < 4; j++) step(1'(vv), 1'b0, 8'd9, 2'b00, 1'b0, -1, -1);
            for (int j = 0; j < 6; j++) begin
                step(1'(vv), (j < 2) ? 1'b1 : 1'b0, 8'd9, 2'b00, 1'b0, -1, -1);
                obs3[j] = int'(bo3);
                obs5[j] = int'(bo5);
            end
            for (int j = 0; j < 6; j++) begin
                chk($sformatf("blank_seq_k3_v%0d_%0d", vv, j), obs3[j], pat[j]);
                chk($sformatf("blank_seq_k5_v%0d_%0d", vv, j), obs5[j], pat[j]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
